// File: rtl/cpu_io_bridge.sv
// ============================================================================
// Module      : cpu_io_bridge
// Description : Host-side endpoint of the CPU's two-word I/O interface. It
//               presents host words on CPUIn and queues CPUOut changes.
//               Optional macro IO_TIMESTAMP_EN adds a per-entry cycle stamp.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_io_bridge #(
  parameter int               WIDTH       = 32,
  parameter int               IN_DEPTH    = 4,
  parameter int               OUT_DEPTH   = 8,
  parameter int               HOLD_CYCLES = 8,
  parameter logic [WIDTH-1:0] RESET_IN    = 32'h00000FFF
) (
  input  logic                          CLK,
  input  logic                          Reset,
  input  logic [WIDTH-1:0]              CPUOut,
  output logic [WIDTH-1:0]              CPUIn,
  input  logic [WIDTH-1:0]              host_in_data,
  input  logic                          host_in_valid,
  output logic                          host_in_ready,
  output logic [WIDTH-1:0]              host_out_data,
  output logic                          host_out_valid,
  input  logic                          host_out_ready,
  output logic                          out_overflow,
`ifdef IO_TIMESTAMP_EN
  output logic [31:0]                   host_out_stamp,
`endif
  output logic [$clog2(IN_DEPTH):0]     in_level
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int CW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_RELOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // ---------------- input FIFO + presenter ----------------
  logic [WIDTH-1:0] in_mem_q [IN_DEPTH];
  logic [IAW:0]     in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] cpuin_q, cpuin_d;
  logic             in_full, in_empty, in_push, in_pop;

  assign in_full       = (in_wr_q[IAW] != in_rd_q[IAW]) &&
                         (in_wr_q[IAW-1:0] == in_rd_q[IAW-1:0]);
  assign in_empty      = (in_wr_q == in_rd_q);
  assign host_in_ready = !in_full;
  assign in_push       = host_in_valid && !in_full;
  assign in_level      = in_wr_q - in_rd_q;
  assign CPUIn         = cpuin_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cpuin_d = cpuin_q;
    in_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!in_empty) begin
          in_pop  = 1'b1;
          cpuin_d = in_mem_q[in_rd_q[IAW-1:0]];
          cnt_d   = HOLD_RELOAD;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!in_empty) begin
          // Reload while the counter expires so consecutive words abut.
          in_pop  = 1'b1;
          cpuin_d = in_mem_q[in_rd_q[IAW-1:0]];
          cnt_d   = HOLD_RELOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_wr_d = in_wr_q + (IAW+1)'(in_push);
    in_rd_d = in_rd_q + (IAW+1)'(in_pop);
  end

  // ---------------- change capture + output FIFO ----------------
  logic [WIDTH-1:0] out_mem_q [OUT_DEPTH];
  logic [OAW:0]     out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [WIDTH-1:0] cpuout_q, cpuout_d;
  logic             ovf_q, ovf_d;
  logic             out_full, out_empty, out_pop, out_push, change;

  assign out_full       = (out_wr_q[OAW] != out_rd_q[OAW]) &&
                          (out_wr_q[OAW-1:0] == out_rd_q[OAW-1:0]);
  assign out_empty      = (out_wr_q == out_rd_q);
  assign host_out_valid = !out_empty;
  assign host_out_data  = out_mem_q[out_rd_q[OAW-1:0]];
  assign out_overflow   = ovf_q;

  always_comb begin
    change   = (CPUOut != cpuout_q);
    out_pop  = host_out_ready && !out_empty;
    // A simultaneous pop frees the slot the push lands in.
    out_push = change && (!out_full || out_pop);
    cpuout_d = change ? CPUOut : cpuout_q;
    ovf_d    = ovf_q | (change && out_full && !out_pop);
    out_wr_d = out_wr_q + (OAW+1)'(out_push);
    out_rd_d = out_rd_q + (OAW+1)'(out_pop);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      in_wr_q  <= '0;
      in_rd_q  <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      cpuin_q  <= RESET_IN;
      out_wr_q <= '0;
      out_rd_q <= '0;
      cpuout_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      in_wr_q  <= in_wr_d;
      in_rd_q  <= in_rd_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cpuin_q  <= cpuin_d;
      out_wr_q <= out_wr_d;
      out_rd_q <= out_rd_d;
      cpuout_q <= cpuout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage arrays need no reset; the pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (in_push) begin
      in_mem_q[in_wr_q[IAW-1:0]] <= host_in_data;
    end
    if (out_push) begin
      out_mem_q[out_wr_q[OAW-1:0]] <= CPUOut;
    end
  end

`ifdef IO_TIMESTAMP_EN
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] stamp_mem_q [OUT_DEPTH];

  assign cycle_d        = cycle_q + 32'd1;
  assign host_out_stamp = stamp_mem_q[out_rd_q[OAW-1:0]];

  always_ff @(posedge CLK) begin
    if (Reset) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (out_push) begin
      stamp_mem_q[out_wr_q[OAW-1:0]] <= cycle_q;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cpu_io_bridge.sv
// ============================================================================
// Module      : tb_cpu_io_bridge
// Description : Directed scoreboard bench for cpu_io_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_io_bridge;

  localparam int OUTD = 8;

  logic        clk = 1'b0;
  logic        Reset;
  logic [31:0] CPUOut;
  logic [31:0] CPUIn;
  logic [31:0] host_in_data;
  logic        host_in_valid;
  logic        host_in_ready;
  logic [31:0] host_out_data;
  logic        host_out_valid;
  logic        host_out_ready;
  logic        out_overflow;
  logic [2:0]  in_level;
`ifdef IO_TIMESTAMP_EN
  logic [31:0] host_out_stamp;
`endif

  always #5 clk = ~clk;

  cpu_io_bridge dut (
    .CLK            (clk),
    .Reset          (Reset),
    .CPUOut         (CPUOut),
    .CPUIn          (CPUIn),
    .host_in_data   (host_in_data),
    .host_in_valid  (host_in_valid),
    .host_in_ready  (host_in_ready),
    .host_out_data  (host_out_data),
    .host_out_valid (host_out_valid),
    .host_out_ready (host_out_ready),
    .out_overflow   (out_overflow),
`ifdef IO_TIMESTAMP_EN
    .host_out_stamp (host_out_stamp),
`endif
    .in_level       (in_level)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] sb_in[$];
  logic [31:0] sb_out[$];
  logic [31:0] last_out    = '0;
  logic        exp_ovf     = 1'b0;
  int          n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic extra(input string tag, input logic [31:0] obs);
    vectors++;
    miscompares++;
    $error("FAIL %s observed=%h expected=none", tag, obs);
  endtask

  // Advance one edge; score host handshakes happening at this edge.
  task automatic tick();
    if (Reset) begin
      sb_out.delete();
      last_out = '0;
      exp_ovf  = 1'b0;
    end else begin
      if (host_in_valid && host_in_ready) sb_in.push_back(host_in_data);
      if (host_out_valid && host_out_ready) begin
        if (sb_out.size() == 0) extra("out_extra", host_out_data);
        else chk("out_data", host_out_data, sb_out.pop_front());
      end
      if (CPUOut != last_out) begin
        if (sb_out.size() < OUTD) sb_out.push_back(CPUOut);
        else exp_ovf = 1'b1;
        last_out = CPUOut;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cpuin(input int gap, input string tag);
    logic [31:0] prev;
    int k;
    prev = CPUIn;
    k = 0;
    do begin
      tick();
      k++;
    end while (CPUIn === prev && k < 20);
    chk({tag, "_gap"}, 32'(k), 32'(gap));
    if (sb_in.size() == 0) extra({tag, "_extra"}, CPUIn);
    else chk(tag, CPUIn, sb_in.pop_front());
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1; CPUOut = '0; host_in_data = '0; host_in_valid = 1'b0;
    host_out_ready = 1'b0;
    tick(); tick();
    chk("reset_cpuin", CPUIn, 32'h00000FFF);
    chk("reset_out_valid", 32'(host_out_valid), 32'd0);
    chk("reset_level", 32'(in_level), 32'd0);
    chk("reset_ovf", 32'(out_overflow), 32'd0);
    chk("reset_in_ready", 32'(host_in_ready), 32'd1);
    Reset = 1'b0;

    // Back-to-back presentation of three words
    host_in_valid = 1'b1; host_in_data = 32'h1;
    tick();
    chk("latency_pre", CPUIn, 32'h00000FFF);
    host_in_data = 32'h2;
    tick();
    chk("cpuin_first", CPUIn, sb_in.pop_front());
    host_in_data = 32'h3;
    tick();
    host_in_valid = 1'b0;
    chk("level_two", 32'(in_level), 32'd2);
    wait_cpuin(7, "w2");
    wait_cpuin(8, "w3");
    repeat (10) tick();
    chk("cpuin_stays", CPUIn, 32'h3);
    chk("level_empty", 32'(in_level), 32'd0);

    // Fill the input FIFO and hold off the extra word
    host_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      host_in_data = 32'h10 + 32'(i);
      tick();
    end
    chk("fill_first", CPUIn, sb_in.pop_front());
    chk("fill_level", 32'(in_level), 32'd4);
    chk("fill_ready", 32'(host_in_ready), 32'd0);
    host_in_data = 32'h15;
    repeat (4) tick();
    chk("held_off", 32'(host_in_ready), 32'd0);
    tick();
    chk("fill_second", CPUIn, sb_in.pop_front());
    chk("pop_frees", 32'(host_in_ready), 32'd1);
    chk("pop_level", 32'(in_level), 32'd3);
    tick();
    host_in_valid = 1'b0;
    chk("refill_level", 32'(in_level), 32'd4);
    wait_cpuin(7, "fill3");
    wait_cpuin(8, "fill4");
    wait_cpuin(8, "fill5");
    wait_cpuin(8, "fill6");
    repeat (10) tick();
    chk("in_sb_empty", 32'(sb_in.size()), 32'd0);

    // Change capture with a draining host
    host_out_ready = 1'b1;
    CPUOut = 32'h0; tick();
    CPUOut = 32'h7; tick();
    CPUOut = 32'h7; tick();
    CPUOut = 32'h9; tick();
    CPUOut = 32'h0; tick();
    repeat (4) tick();
    chk("chg_drained", 32'(sb_out.size()), 32'd0);
    chk("chg_valid", 32'(host_out_valid), 32'd0);
    chk("chg_ovf", 32'(out_overflow), 32'(exp_ovf));

    // Overflow with a stalled host
    host_out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      CPUOut = 32'h100 + 32'(i);
      tick();
    end
    chk("ovf_set", 32'(out_overflow), 32'(exp_ovf));
    chk("ovf_retained", 32'(sb_out.size()), 32'd8);
    host_out_ready = 1'b1;
    n = 0;
    while (sb_out.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("ovf_drained", 32'(sb_out.size()), 32'd0);
    tick();
    chk("ovf_valid", 32'(host_out_valid), 32'd0);
    chk("ovf_sticky", 32'(out_overflow), 32'd1);

    // Reset mid-operation
    host_out_ready = 1'b0;
    host_in_valid = 1'b1;
    host_in_data = 32'hA1; tick();
    host_in_data = 32'hA2; tick();
    host_in_data = 32'hA3; tick();
    host_in_valid = 1'b0;
    chk("pre_rst_level", 32'(in_level), 32'd2);
    CPUOut = 32'h201; tick();
    CPUOut = 32'h202; tick();
    CPUOut = 32'h203; tick();
    chk("pre_rst_valid", 32'(host_out_valid), 32'd1);
    Reset = 1'b1; CPUOut = '0;
    tick();
    sb_in.delete();
    chk("rst_cpuin", CPUIn, 32'h00000FFF);
    chk("rst_level", 32'(in_level), 32'd0);
    chk("rst_out_valid", 32'(host_out_valid), 32'd0);
    chk("rst_ovf", 32'(out_overflow), 32'd0);
    chk("rst_in_ready", 32'(host_in_ready), 32'd1);
    Reset = 1'b0;
    repeat (5) tick();
    CPUOut = 32'h55;
    tick();
    chk("post_rst_valid", 32'(host_out_valid), 32'd1);
    chk("post_rst_data", host_out_data, 32'h55);
`ifdef IO_TIMESTAMP_EN
    chk("post_rst_stamp", host_out_stamp, 32'd5);
`endif
    host_out_ready = 1'b1;
    tick(); tick();
    chk("final_drained", 32'(sb_out.size()), 32'd0);
    chk("final_cpuin", CPUIn, 32'h00000FFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
